// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake bundle between the pipeline and the iterative RV32M mul/div unit.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, funct3_i, src_a_i, src_b_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, src_a_i, src_b_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  muldiv_sequencer_if.slave   bus
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [CW-1:0]     counter_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              is_div;
  logic              a_signed;
  logic              b_signed;
  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   calc_res;

  function automatic logic [XLEN-1:0] sel_result(
    input logic [2:0]        f3,
    input logic [2*XLEN-1:0] prod,
    input logic [XLEN-1:0]   quo,
    input logic [XLEN-1:0]   rem
  );
    logic [XLEN-1:0] r;
    case (f3)
      3'b000:                  r = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011:  r = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:          r = quo;
      default:                 r = rem;
    endcase
    return r;
  endfunction

  assign accept = (state_q == IDLE) && bus.start_i && !bus.flush_i;

  // A flush in CALC withdraws the stall in the same cycle the abort is requested.
  assign bus.busy_o   = ((state_q == CALC) && !bus.flush_i) || accept;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

  always_comb begin
    is_div   = bus.funct3_i[2];
    a_signed = is_div ? !bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
    b_signed = is_div ? !bus.funct3_i[0] : !bus.funct3_i[1];
    sa       = a_signed && bus.src_a_i[XLEN-1];
    sb       = b_signed && bus.src_b_i[XLEN-1];
    abs_a    = sa ? -bus.src_a_i : bus.src_a_i;
    abs_b    = sb ? -bus.src_b_i : bus.src_b_i;
    div_zero = is_div && (bus.src_b_i == '0);
    div_ovf  = is_div && !bus.funct3_i[0] &&
               (bus.src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src_b_i == '1);
    if (div_zero)
      special_res = bus.funct3_i[1] ? bus.src_a_i : '1;
    else
      special_res = bus.funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Multiply keeps {partial product, remaining multiplier} in acc; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (f3_q[2])
      acc_d = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
               acc_q[XLEN-2:0], ~div_diff[XLEN]};
    else
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    prod_fix = neg_res_q ? -acc_d : acc_d;
    quo_fix  = neg_res_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    rem_fix  = neg_rem_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    calc_res = sel_result(f3_q, prod_fix, quo_fix, rem_fix);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a;
  logic signed [XLEN:0]     fast_b;
  logic signed [2*XLEN+1:0] fast_full;
  logic [XLEN-1:0]          fast_res;

  always_comb begin
    fast_a    = {a_signed && bus.src_a_i[XLEN-1], bus.src_a_i};
    fast_b    = {b_signed && bus.src_b_i[XLEN-1], bus.src_b_i};
    fast_full = fast_a * fast_b;
    fast_res  = sel_result(bus.funct3_i, fast_full[2*XLEN-1:0], '0, '0);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      f3_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      counter_q <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            f3_q      <= bus.funct3_i;
            a_q       <= abs_a;
            b_q       <= abs_b;
            acc_q     <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
            counter_q <= '0;
            neg_res_q <= sa ^ sb;
            neg_rem_q <= sa;
            if (div_zero || div_ovf) begin
              state_q  <= DONE;
              result_q <= special_res;
              done_q   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div) begin
              state_q  <= DONE;
              result_q <= fast_res;
              done_q   <= 1'b1;
`endif
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush_i) begin
            state_q <= IDLE;
          end else begin
            acc_q     <= acc_d;
            counter_q <= counter_q + CW'(1);
            if (counter_q == CW'(XLEN - 1)) begin
              state_q  <= DONE;
              result_q <= calc_res;
              done_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer; expected latencies follow MULDIV_FAST_MUL_EN if defined.
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation from IDLE and measures its latency; no checking here.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res,
                       output int busy_cnt, output logic busy_at_done);
    bus.start_i  = 1'b1;
    bus.funct3_i = f3;
    bus.src_a_i  = a;
    bus.src_b_i  = b;
    #1;
    busy_cnt = (bus.busy_o === 1'b1) ? 1 : 0;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    lat = 1;
    while (bus.done_o !== 1'b1 && lat < 40) begin
      if (bus.busy_o === 1'b1) busy_cnt++;
      step();
      lat++;
    end
    busy_at_done = bus.busy_o;
    res = bus.result_o;
    step();
  endtask

  task automatic test_reset();
    bus.start_i  = 1'b0;
    bus.flush_i  = 1'b0;
    bus.funct3_i = 3'b000;
    bus.src_a_i  = '0;
    bus.src_b_i  = '0;
    reset_n = 1'b0;
    step();
    step();
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy_o); else n_pass++;
    n_total++; if (bus.done_o !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done_o); else n_pass++;
    n_total++; if (bus.result_o !== 32'h0) $display("FAIL reset_result got=%h exp=0", bus.result_o); else n_pass++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_mul();
    int lat; logic [31:0] res; int bc; logic bd;
    issue(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, lat, res, bc, bd);
    n_total++; if (lat !== MUL_LAT) $display("FAIL mul_latency got=%0d exp=%0d", lat, MUL_LAT); else n_pass++;
    n_total++; if (res !== 32'hFFFF_FFEB) $display("FAIL mul_result got=%h exp=ffffffeb", res); else n_pass++;
    n_total++; if (bc !== MUL_LAT) $display("FAIL mul_busy_cycles got=%0d exp=%0d", bc, MUL_LAT); else n_pass++;
    n_total++; if (bd !== 1'b0) $display("FAIL mul_busy_in_done got=%b exp=0", bd); else n_pass++;
    n_total++; if (bus.result_o !== 32'hFFFF_FFEB) $display("FAIL mul_result_hold got=%h exp=ffffffeb", bus.result_o); else n_pass++;
  endtask

  task automatic test_mulh();
    int lat; logic [31:0] res; int bc; logic bd;
    logic [2:0]  f3v [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] av  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bv  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev  [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      issue(f3v[i], av[i], bv[i], lat, res, bc, bd);
      n_total++; if (res !== ev[i]) $display("FAIL mulh_result[%0d] got=%h exp=%h", i, res, ev[i]); else n_pass++;
      n_total++; if (lat !== MUL_LAT) $display("FAIL mulh_latency[%0d] got=%0d exp=%0d", i, lat, MUL_LAT); else n_pass++;
    end
  endtask

  task automatic test_div();
    int lat; logic [31:0] res; int bc; logic bd;
    logic [2:0]  f3v [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] av  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bv  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ev  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      issue(f3v[i], av[i], bv[i], lat, res, bc, bd);
      n_total++; if (res !== ev[i]) $display("FAIL div_result[%0d] got=%h exp=%h", i, res, ev[i]); else n_pass++;
      n_total++; if (lat !== DIV_LAT) $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, lat, DIV_LAT); else n_pass++;
    end
  endtask

  task automatic test_special();
    int lat; logic [31:0] res; int bc; logic bd;
    logic [2:0]  f3v [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] av  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    for (int i = 0; i < 4; i++) begin
      issue(f3v[i], av[i], bv[i], lat, res, bc, bd);
      n_total++; if (res !== ev[i]) $display("FAIL special_result[%0d] got=%h exp=%h", i, res, ev[i]); else n_pass++;
      n_total++; if (lat !== 1) $display("FAIL special_latency[%0d] got=%0d exp=1", i, lat); else n_pass++;
    end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res; int bc; logic bd; int seen;
    issue(3'b111, 32'd100, 32'd7, lat, res, bc, bd);
    // start+flush together in IDLE: nothing accepted
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.funct3_i = 3'b101;
    bus.src_a_i = 32'd50; bus.src_b_i = 32'd5;
    #1;
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL flush_idle_busy got=%b exp=0", bus.busy_o); else n_pass++;
    step();
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL flush_idle_no_accept got=%b exp=0", bus.busy_o); else n_pass++;
    // accept DIVU 100/7 at t, flush at iteration 10 (cycle t+11)
    bus.start_i = 1'b1; bus.funct3_i = 3'b101; bus.src_a_i = 32'd100; bus.src_b_i = 32'd7;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL flush_calc_busy got=%b exp=0", bus.busy_o); else n_pass++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o === 1'b1) seen++;
      step();
    end
    n_total++; if (seen !== 0) $display("FAIL flush_no_done got=%0d exp=0", seen); else n_pass++;
    n_total++; if (bus.result_o !== 32'd2) $display("FAIL flush_result_hold got=%h exp=00000002", bus.result_o); else n_pass++;
    issue(3'b101, 32'd100, 32'd7, lat, res, bc, bd);
    n_total++; if (res !== 32'd14) $display("FAIL flush_restart_result got=%h exp=0000000e", res); else n_pass++;
    n_total++; if (lat !== DIV_LAT) $display("FAIL flush_restart_latency got=%0d exp=%0d", lat, DIV_LAT); else n_pass++;
  endtask

  task automatic test_ignore_start();
    int lat; logic busy_mid;
    bus.start_i = 1'b1; bus.funct3_i = 3'b100; bus.src_a_i = 32'd100; bus.src_b_i = 32'd7;
    step();
    bus.start_i = 1'b0;
    lat = 1;
    for (int i = 0; i < 5; i++) begin step(); lat++; end
    bus.start_i = 1'b1; bus.funct3_i = 3'b101; bus.src_a_i = 32'd9; bus.src_b_i = 32'd3;
    #1;
    busy_mid = bus.busy_o;
    step();
    lat++;
    bus.start_i = 1'b0;
    while (bus.done_o !== 1'b1 && lat < 40) begin step(); lat++; end
    n_total++; if (busy_mid !== 1'b1) $display("FAIL ignore_busy got=%b exp=1", busy_mid); else n_pass++;
    n_total++; if (bus.result_o !== 32'd14) $display("FAIL ignore_result got=%h exp=0000000e", bus.result_o); else n_pass++;
    n_total++; if (lat !== DIV_LAT) $display("FAIL ignore_latency got=%0d exp=%0d", lat, DIV_LAT); else n_pass++;
    step();
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL ignore_back_to_idle got=%b exp=0", bus.busy_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.start_i = 1'b1; bus.funct3_i = 3'b100; bus.src_a_i = 32'd1000; bus.src_b_i = 32'd3;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_total++; if (bus.busy_o !== 1'b1) $display("FAIL rstmid_busy_before got=%b exp=1", bus.busy_o); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", bus.busy_o); else n_pass++;
    n_total++; if (bus.result_o !== 32'h0) $display("FAIL rstmid_result got=%h exp=0", bus.result_o); else n_pass++;
    n_total++; if (bus.done_o !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", bus.done_o); else n_pass++;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_ignore_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
